// File: rtl/tac_pkg.sv
// tac_pkg: opcodes, subcodes, reset values and helpers shared by the TAC blocks
package tac_pkg;
  localparam logic [3:0] OP_READ  = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_START = 4'd2;
  localparam logic [3:0] OP_STOP  = 4'd3;
  localparam logic [3:0] SUB_PERIOD = 4'd1;
  localparam logic [3:0] SUB_DELAY  = 4'd2;
  localparam logic [3:0] SUB_WIDTH  = 4'd3;
  localparam logic [3:0] SUB_COUNT  = 4'd4;
  localparam logic [3:0] SUB_SWEEP  = 4'd5;
  localparam logic [3:0] SUB_PEMIT  = 4'hb;
  localparam logic [3:0] SUB_BUSY   = 4'hc;
  localparam logic [15:0] PERIOD_RST = 16'd1000;
  localparam logic [6:0]  DELAY_RST  = 7'd0;
  localparam logic [3:0]  WIDTH_RST  = 4'd1;
  localparam logic [15:0] COUNT_RST  = 16'd0;
  localparam logic        SWEEP_RST  = 1'b0;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  function automatic logic [15:0] eff_period(input logic [15:0] p);
    return (p < 16'd2) ? 16'd2 : p;
  endfunction
  function automatic logic [3:0] eff_width(input logic [3:0] w);
    return (w == 4'd0) ? 4'd1 : w;
  endfunction
endpackage

// File: rtl/tac_pulse_window.sv
// tac_pulse_window: registered flag, high while phase lies in [start, start+width)
module tac_pulse_window (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        en_in,
  input  logic [15:0] phase_in,
  input  logic [15:0] start_in,
  input  logic [15:0] width_in,
  output logic        pulse_out
);
  logic [16:0] end_d;
  logic        pulse_d, pulse_q;
  always_comb begin
    end_d   = {1'b0, start_in} + {1'b0, width_in};
    pulse_d = en_in && (phase_in >= start_in) && ({1'b0, phase_in} < end_d);
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) pulse_q <= 1'b0;
    else pulse_q <= pulse_d;
  assign pulse_out = pulse_q;
endmodule

// File: rtl/tac_pulse_gen.sv
// tac_pulse_gen: emulated sync/photon pulse generator with command-driven config and readback
module tac_pulse_gen import tac_pkg::*; (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cmd_trig_in,
  input  logic [15:0] cmd_in,
  input  logic [15:0] data_in,
  output logic        sync_out,
  output logic        pmt_out,
  output logic        busy_out,
  output logic [15:0] wOutData0_out,
  output logic [15:0] wOutData1_out
);
  state_e      state_q, state_d;
  logic [15:0] period_q, period_d, count_q, count_d, phase_q, phase_d, eff_period_q, eff_period_d;
  logic [6:0]  delay_q, delay_d, act_delay_q, act_delay_d;
  logic [3:0]  width_q, width_d, eff_width_q, eff_width_d;
  logic        sweep_q, sweep_d;
  logic [31:0] pemit_q, pemit_d, rdata_q, rdata_d, pemit_inc, rsel;
  logic [3:0]  op, sub;
  logic        wr, rd, run, start, stop, wrap, terminal;
  logic        unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_in[11:4];
  always_comb begin
    op        = cmd_in[15:12];
    sub       = cmd_in[3:0];
    wr        = cmd_trig_in && op == OP_WRITE;
    rd        = cmd_trig_in && op == OP_READ;
    run       = state_q == ST_RUN;
    start     = cmd_trig_in && op == OP_START && !run;
    stop      = cmd_trig_in && op == OP_STOP;
    period_d  = (wr && sub == SUB_PERIOD) ? data_in : period_q;
    delay_d   = (wr && sub == SUB_DELAY) ? data_in[6:0] : delay_q;
    width_d   = (wr && sub == SUB_WIDTH) ? data_in[3:0] : width_q;
    count_d   = (wr && sub == SUB_COUNT) ? data_in : count_q;
    sweep_d   = (wr && sub == SUB_SWEEP) ? data_in[0] : sweep_q;
    wrap      = run && phase_q == eff_period_q - 16'd1;
    pemit_inc = (pemit_q == 32'hFFFF_FFFF) ? pemit_q : pemit_q + 32'd1;
    terminal  = wrap && count_q != 16'd0 && pemit_inc == {16'd0, count_q};
    state_d      = state_q;
    phase_d      = phase_q;
    eff_period_d = eff_period_q;
    eff_width_d  = eff_width_q;
    act_delay_d  = act_delay_q;
    pemit_d      = pemit_q;
    if (start) begin
      state_d      = ST_RUN;
      phase_d      = 16'd0;
      eff_period_d = eff_period(period_q);
      eff_width_d  = eff_width(width_q);
      act_delay_d  = delay_q;
      pemit_d      = 32'd0;
    end else if (run) begin
      phase_d = wrap ? 16'd0 : phase_q + 16'd1;
      state_d = (stop || terminal) ? ST_IDLE : ST_RUN;
      if (wrap) begin
        eff_period_d = eff_period(period_q);
        eff_width_d  = eff_width(width_q);
        act_delay_d  = sweep_q ? act_delay_q + 7'd1 : delay_q;
        pemit_d      = pemit_inc;
      end
    end
    rsel = (sub == SUB_PERIOD) ? {16'd0, period_q} :
           (sub == SUB_DELAY)  ? {25'd0, act_delay_q} :
           (sub == SUB_WIDTH)  ? {28'd0, width_q} :
           (sub == SUB_COUNT)  ? {16'd0, count_q} :
           (sub == SUB_PEMIT)  ? pemit_q :
           (sub == SUB_BUSY)   ? {31'd0, run} : 32'd0;
    rdata_d = rd ? rsel : rdata_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      period_q     <= PERIOD_RST;
      delay_q      <= DELAY_RST;
      width_q      <= WIDTH_RST;
      count_q      <= COUNT_RST;
      sweep_q      <= SWEEP_RST;
      phase_q      <= 16'd0;
      eff_period_q <= 16'd0;
      eff_width_q  <= 4'd0;
      act_delay_q  <= 7'd0;
      pemit_q      <= 32'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      delay_q      <= delay_d;
      width_q      <= width_d;
      count_q      <= count_d;
      sweep_q      <= sweep_d;
      phase_q      <= phase_d;
      eff_period_q <= eff_period_d;
      eff_width_q  <= eff_width_d;
      act_delay_q  <= act_delay_d;
      pemit_q      <= pemit_d;
      rdata_q      <= rdata_d;
    end
  // Windows see next-cycle phase/shadows so the registered pulses line up with phase_q
  tac_pulse_window u_sync (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(state_d == ST_RUN), .phase_in(phase_d),
    .start_in(16'd0), .width_in({12'd0, eff_width_d}), .pulse_out(sync_out)
  );
  tac_pulse_window u_pmt (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(state_d == ST_RUN), .phase_in(phase_d),
    .start_in({9'd0, act_delay_d}), .width_in({12'd0, eff_width_d}), .pulse_out(pmt_out)
  );
  assign busy_out      = run;
  assign wOutData0_out = rdata_q[15:0];
  assign wOutData1_out = rdata_q[31:16];
endmodule

// File: tb/tb_tac_pulse_gen.sv
// tb_tac_pulse_gen: directed checks of pulse timing, sweep, count, stop, readback and reset
module tb_tac_pulse_gen;
  import tac_pkg::*;
  logic        clk_in = 1'b0, rst_n_in = 1'b0, cmd_trig_in = 1'b0;
  logic [15:0] cmd_in = 16'd0, data_in = 16'd0;
  logic        sync_out, pmt_out, busy_out;
  logic [15:0] wOutData0_out, wOutData1_out;
  int n_chk = 0, n_err = 0;
  tac_pulse_gen dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .cmd_trig_in(cmd_trig_in), .cmd_in(cmd_in),
    .data_in(data_in), .sync_out(sync_out), .pmt_out(pmt_out), .busy_out(busy_out),
    .wOutData0_out(wOutData0_out), .wOutData1_out(wOutData1_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic cmd(input logic [3:0] op, input logic [3:0] sub, input logic [15:0] d);
    cmd_in      = {op, 8'h00, sub};
    data_in     = d;
    cmd_trig_in = 1'b1;
    tick;
    cmd_trig_in = 1'b0;
    cmd_in      = 16'd0;
    data_in     = 16'd0;
  endtask
  task automatic cfg(input logic [15:0] per, input logic [15:0] dly, input logic [15:0] wid,
                     input logic [15:0] cnt);
    cmd(OP_WRITE, SUB_PERIOD, per);
    cmd(OP_WRITE, SUB_DELAY, dly);
    cmd(OP_WRITE, SUB_WIDTH, wid);
    cmd(OP_WRITE, SUB_COUNT, cnt);
  endtask
  initial begin
    int ph, per, rises;
    logic prev;
    #22 rst_n_in = 1'b1;
    tick;
    check("rst sync", sync_out, 0);
    check("rst pmt", pmt_out, 0);
    check("rst busy", busy_out, 0);
    check("rst rdata", {wOutData1_out, wOutData0_out}, 0);
    cmd(OP_READ, SUB_PERIOD, 0);
    check("rst period", {wOutData1_out, wOutData0_out}, 1000);
    // basic: period 10, width 2, delay 4, three periods
    cfg(10, 4, 2, 3);
    cmd(OP_START, 0, 0);
    for (int i = 0; i < 30; i++) begin
      ph = i % 10;
      check("basic sync", sync_out, ph < 2);
      check("basic pmt", pmt_out, ph >= 4 && ph < 6);
      check("basic busy", busy_out, 1);
      tick;
    end
    check("basic done busy", busy_out, 0);
    check("basic done sync", sync_out, 0);
    cmd(OP_READ, SUB_PEMIT, 0);
    check("basic pemit", {wOutData1_out, wOutData0_out}, 3);
    cmd(OP_READ, SUB_DELAY, 0);
    check("basic act delay", {wOutData1_out, wOutData0_out}, 4);
    cmd(OP_READ, 4'd7, 0);
    check("read unknown sub", {wOutData1_out, wOutData0_out}, 0);
    // delay 0: pmt identical to sync
    cfg(10, 0, 3, 0);
    cmd(OP_START, 0, 0);
    for (int i = 0; i < 25; i++) begin
      check("d0 sync", sync_out, (i % 10) < 3);
      check("d0 pmt eq sync", pmt_out, (i % 10) < 3);
      tick;
    end
    cmd(OP_STOP, 0, 0);
    check("d0 stop busy", busy_out, 0);
    check("d0 stop sync", sync_out, 0);
    // truncated pmt window
    cfg(8, 6, 4, 2);
    cmd(OP_START, 0, 0);
    for (int i = 0; i < 16; i++) begin
      ph = i % 8;
      check("trunc sync", sync_out, ph < 4);
      check("trunc pmt", pmt_out, ph >= 6);
      tick;
    end
    check("trunc done busy", busy_out, 0);
    // delay sweep across the 127 -> 0 wrap
    cmd(OP_WRITE, SUB_SWEEP, 1);
    cfg(200, 126, 1, 4);
    cmd(OP_START, 0, 0);
    prev = 1'b0;
    rises = 0;
    for (int i = 0; i < 800; i++) begin
      ph = i % 200;
      check("sweep pmt", pmt_out, ph == ((126 + i / 200) % 128));
      if (pmt_out && !prev) rises++;
      prev = pmt_out;
      tick;
    end
    check("sweep rises", rises, 4);
    check("sweep done busy", busy_out, 0);
    cmd(OP_READ, SUB_DELAY, 0);
    check("sweep act delay", {wOutData1_out, wOutData0_out}, 2);
    cmd(OP_WRITE, SUB_SWEEP, 0);
    // period change mid-run, then stop mid-pulse
    cfg(50, 2, 8, 0);
    cmd(OP_START, 0, 0);
    cmd(OP_READ, SUB_BUSY, 0);
    check("run busy read", {wOutData1_out, wOutData0_out}, 1);
    repeat (4) tick;
    cmd(OP_WRITE, SUB_PERIOD, 20);
    ph = 6;
    per = 50;
    check("chg sync", sync_out, 1);
    repeat (67) begin
      tick;
      if (ph == per - 1) begin
        ph = 0;
        per = 20;
      end else ph++;
      check("chg sync", sync_out, ph < 8);
      check("chg pmt", pmt_out, ph >= 2 && ph < 10);
    end
    check("pre-stop pmt", pmt_out, 1);
    cmd(OP_STOP, 0, 0);
    check("stop sync", sync_out, 0);
    check("stop pmt", pmt_out, 0);
    check("stop busy", busy_out, 0);
    // degenerate period/width clamp to 2/1
    cfg(1, 0, 0, 2);
    cmd(OP_START, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("clamp sync", sync_out, (i % 2) == 0);
      check("clamp pmt", pmt_out, (i % 2) == 0);
      check("clamp busy", busy_out, 1);
      tick;
    end
    check("clamp done busy", busy_out, 0);
    cmd(OP_READ, SUB_PERIOD, 0);
    check("clamp raw period", {wOutData1_out, wOutData0_out}, 1);
    cmd(OP_READ, SUB_COUNT, 0);
    check("clamp count", {wOutData1_out, wOutData0_out}, 2);
    // asynchronous reset mid pmt pulse
    cfg(20, 2, 8, 0);
    cmd(OP_START, 0, 0);
    repeat (4) tick;
    check("pre-rst pmt", pmt_out, 1);
    #1 rst_n_in = 1'b0;
    #1;
    check("arst sync", sync_out, 0);
    check("arst pmt", pmt_out, 0);
    check("arst busy", busy_out, 0);
    check("arst rdata", {wOutData1_out, wOutData0_out}, 0);
    #3 rst_n_in = 1'b1;
    tick;
    tick;
    check("post-rst busy", busy_out, 0);
    check("post-rst sync", sync_out, 0);
    cmd(OP_READ, SUB_PERIOD, 0);
    check("post-rst period", {wOutData1_out, wOutData0_out}, 1000);
    cmd(OP_READ, SUB_BUSY, 0);
    check("post-rst busy read", {wOutData1_out, wOutData0_out}, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tac_pulse_gen.md
TAC_PULSE_GEN -- requirements
Module: tac_pulse_gen

Interface
REQ-001 clk_in  input  1  USB-domain clock; all logic is on its rising edge; this is the only clock.
REQ-002 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-003 cmd_trig_in  input  1  one-cycle command strobe.
REQ-004 cmd_in  input  16  opcode in [15:12], subcode in [3:0].
REQ-005 data_in  input  16  write operand.
REQ-006 sync_out  output  1  emulated sync pulse, registered.
REQ-007 pmt_out  output  1  emulated photon pulse, registered.
REQ-008 busy_out  output  1  high while state is RUN.
REQ-009 wOutData0_out / wOutData1_out  output  16 each  readback low/high words, registered.

Function
REQ-010 Config registers SHALL be: PERIOD 16b (reset 1000), DELAY 7b (reset 0), WIDTH 4b (reset 1), COUNT 16b (reset 0), SWEEP 1b (reset 0).
REQ-011 Opcode 1 (WRITE) SHALL load data_in into the register selected by the subcode: 1 PERIOD, 2 DELAY[6:0], 3 WIDTH[3:0], 4 COUNT, 5 SWEEP = data_in[0]; other subcodes are ignored.
REQ-012 Opcode 2 (START) SHALL move the block from IDLE to RUN; in RUN it is ignored.
REQ-013 Opcode 3 (STOP) SHALL move the block to IDLE.
REQ-014 Opcode 0 (READ) SHALL drive {wOutData1_out, wOutData0_out} on the next cycle as follows.
- Subcode 1: {0, PERIOD}.
- Subcode 2: {0, active delay}.
- Subcode 3: {0, WIDTH}.
- Subcode 4: {0, COUNT}.
- Subcode 0xb: 32-bit periods-emitted counter.
- Subcode 0xc: {0, 15'b0, busy}.
- Any other subcode: 0.
REQ-015 FSM states SHALL be IDLE and RUN only; in IDLE, sync_out = pmt_out = 0.
REQ-016 On entering RUN, the block SHALL latch shadow copies: effective period = max(PERIOD, 2), effective width = max(WIDTH, 1), active delay = DELAY.
- It SHALL clear the phase counter and the periods-emitted counter.
REQ-017 The phase counter SHALL run 0..effective period-1 and then wrap to 0.
REQ-018 Shadow registers SHALL reload from the config registers at every wrap, so writes made during RUN take effect at the next period.
REQ-019 Output timing:
- sync_out SHALL be high when phase < effective width.
- pmt_out SHALL be high when active delay <= phase < active delay + effective width.
- Both outputs are registered, so the first sync_out high appears the cycle after the START strobe is sampled.
REQ-020 Pulses SHALL never span a wrap: a pmt window that would extend past period-1 is truncated at the wrap, and so is a sync width larger than the period.
REQ-021 DELAY = 0 SHALL make pmt_out coincide exactly with sync_out.
REQ-022 With SWEEP = 1, the active delay SHALL increment by 1 at each wrap, wrapping 127 -> 0; SWEEP = 0 reloads DELAY instead.
REQ-023 The periods-emitted counter SHALL increment at each wrap and saturate at 0xFFFFFFFF.
REQ-024 With COUNT != 0, the block SHALL return to IDLE at the wrap on which periods-emitted reaches COUNT; COUNT = 0 means free-running.
REQ-025 A STOP received mid-period SHALL force both outputs low on the next cycle; periods-emitted keeps its value for readback.
REQ-026 A write and a START in the same cycle cannot occur (single strobe); a START and a terminal wrap in the same cycle SHALL resolve to IDLE.

Reset
REQ-027 Asserting rst_n_in low SHALL asynchronously do all of the following:
- Force IDLE.
- Load the REQ-010 reset values.
- Clear the phase, shadow and periods-emitted registers.
- Drive sync_out = pmt_out = busy_out = 0 and wOutData0_out = wOutData1_out = 0.
REQ-028 A reset asserted mid-RUN SHALL take effect immediately, with no partial pulse completion.
REQ-029 After release, the block SHALL stay in IDLE until a START is received.

Structure
REQ-030 The opcode constants (READ 0, WRITE 1, START 2, STOP 3), the subcode constants and the register reset values SHALL live in the shared package tac_pkg, which the TAC histogram decoder also uses.
REQ-031 A sub-module tac_pulse_window (registered compare of phase against start/width, producing one output) is natural and SHALL be instantiated twice, once for sync and once for pmt.
REQ-032 The target size SHALL be 150-300 lines of RTL.

Verification
REQ-033 PERIOD=10, WIDTH=2, DELAY=4, COUNT=3, START -> sync_out high on phases 0-1 and pmt_out high on phases 4-5, three times; busy drops after 30 cycles; READ 0xb returns 3.
REQ-034 DELAY=0, WIDTH=3 -> pmt_out is identical to sync_out in every cycle.
REQ-035 PERIOD=8, DELAY=6, WIDTH=4 -> pmt_out high on phases 6-7 only (truncated); no high at phase 0 of the next period.
REQ-036 SWEEP=1, DELAY=126, PERIOD=200, COUNT=4 -> pmt rising edges at phases 126, 127, 0, 1; READ 2 after stop returns 2.
REQ-037 COUNT=0, write PERIOD=20 at phase 5 of a 50-cycle period -> the current period stays 50 and the next is 20; STOP at phase 3 -> outputs are 0 on the next cycle and busy_out = 0.
REQ-038 rst_n_in pulsed low mid-pmt pulse -> outputs go 0 asynchronously; READ 1 returns 1000 and READ 0xc returns 0.
